// File: rtl/core_registers.sv
// core_registers: 16-entry register file with constant slots, bus-overlay register and auto-incrementing PC.
module core_registers (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addr_read,
  input  logic [3:0]  addr_write,
  input  logic [15:0] data_write,
  input  logic        write_enable,
  input  logic [15:0] bus_datain,
  input  logic        bus_fromin,
  input  logic        pc_inc,
  output logic [15:0] data_read,
  output logic [15:0] pc_out,
  output logic [15:0] reg_h_out
);
  logic [15:0] gpr_q [11];
  logic [15:0] bus_q, pc_q, pc_d;
  logic        wr_pc;
  assign wr_pc = write_enable && addr_write == 4'hF;
  // An explicit PC write takes priority over the increment.
  assign pc_d = wr_pc ? data_write : pc_q + {15'd0, pc_inc};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) gpr_q[i] <= '0;
      bus_q <= '0;
      pc_q  <= '0;
    end else begin
      if (write_enable && addr_write <= 4'hA) gpr_q[addr_write] <= data_write;
      if (write_enable && addr_write == 4'hE) bus_q <= data_write;
      pc_q <= pc_d;
    end
  end
  always_comb begin
    case (addr_read)
      4'hB:    data_read = 16'h0000;
      4'hC:    data_read = 16'h0001;
      4'hD:    data_read = 16'hFFFF;
      4'hE:    data_read = bus_fromin ? bus_datain : bus_q;
      4'hF:    data_read = pc_q;
      default: data_read = gpr_q[addr_read];
    endcase
  end
  assign pc_out    = pc_q;
  assign reg_h_out = gpr_q[7];
endmodule

// File: tb/tb_core_registers.sv
// tb_core_registers: directed stimulus checked against a register-map model every cycle plus literal spot checks.
module tb_core_registers;
  logic        clk = 0, rst = 1;
  logic [3:0]  addr_read = 0, addr_write = 0;
  logic [15:0] data_write = 0, bus_datain = 0;
  logic        write_enable = 0, bus_fromin = 0, pc_inc = 0;
  logic [15:0] data_read, pc_out, reg_h_out;
  int n_cmp = 0, n_err = 0;

  core_registers dut (
    .clk(clk), .rst(rst), .addr_read(addr_read), .addr_write(addr_write),
    .data_write(data_write), .write_enable(write_enable), .bus_datain(bus_datain),
    .bus_fromin(bus_fromin), .pc_inc(pc_inc), .data_read(data_read),
    .pc_out(pc_out), .reg_h_out(reg_h_out)
  );

  always #5 clk = ~clk;

  // Model storage indexed by register number; slots 0xB-0xD are never stored.
  logic [15:0] m [16];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m[i] = 16'h0000;
    end else begin
      if (!(write_enable && addr_write == 4'hF) && pc_inc) m[15] = m[15] + 16'd1;
      if (write_enable && !(addr_write inside {4'hB, 4'hC, 4'hD})) m[addr_write] = data_write;
    end
  end

  function automatic logic [15:0] exp_rd(input logic [3:0] a);
    if (a == 4'hB) return 16'h0000;
    if (a == 4'hC) return 16'h0001;
    if (a == 4'hD) return 16'hFFFF;
    if (a == 4'hE && bus_fromin) return bus_datain;
    return m[a];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model data_read", data_read, exp_rd(addr_read));
    chk("model pc_out", pc_out, m[15]);
    chk("model reg_h_out", reg_h_out, m[7]);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic inc);
    addr_write = a; data_write = d; write_enable = 1; pc_inc = inc;
    step();
    write_enable = 0; pc_inc = 0;
  endtask

  initial begin
    repeat (2) step();
    chk("reset pc", pc_out, 16'h0000);
    chk("reset h", reg_h_out, 16'h0000);
    rst = 0;
    pc_inc = 1;
    repeat (3) step();
    pc_inc = 0;
    chk("pc inc x3", pc_out, 16'h0003);
    addr_read = 4'h3; addr_write = 4'h3; data_write = 16'h1234; write_enable = 1;
    #1 chk("same-cycle read old", data_read, 16'h0000);
    step();
    write_enable = 0;
    chk("read after write", data_read, 16'h1234);
    for (int a = 11; a <= 13; a++) wr(4'(a), 16'hAAAA, 0);
    addr_read = 4'hB; #1 chk("const B", data_read, 16'h0000);
    addr_read = 4'hC; #1 chk("const C", data_read, 16'h0001);
    addr_read = 4'hD; #1 chk("const D", data_read, 16'hFFFF);
    wr(4'hF, 16'hFFFF, 0);
    chk("pc load", pc_out, 16'hFFFF);
    pc_inc = 1; step(); pc_inc = 0;
    chk("pc wrap", pc_out, 16'h0000);
    wr(4'hF, 16'h0100, 1);
    chk("pc write wins", pc_out, 16'h0100);
    wr(4'h7, 16'hBEEF, 1);
    chk("h tap", reg_h_out, 16'hBEEF);
    chk("pc parallel inc", pc_out, 16'h0101);
    bus_fromin = 1; bus_datain = 16'h9999;
    wr(4'hE, 16'h5555, 0);
    addr_read = 4'hE;
    #1 chk("bus overlay", data_read, 16'h9999);
    bus_fromin = 0;
    #1 chk("bus stored", data_read, 16'h5555);
    for (int a = 0; a < 16; a++) wr(4'(a), 16'(a * 16'h1111 + 16'h0F0F), a[0]);
    for (int a = 0; a < 16; a++) begin
      addr_read = 4'(a);
      bus_datain = 16'(a * 7);
      bus_fromin = a[1];
      step();
    end
    bus_fromin = 0;
    addr_read = 4'h9;
    repeat (3) step();
    addr_read = 4'h3;
    addr_write = 4'h4; data_write = 16'hCAFE; write_enable = 1; pc_inc = 1;
    #1 rst = 1;
    #1;
    chk("async pc", pc_out, 16'h0000);
    chk("async h", reg_h_out, 16'h0000);
    chk("async read", data_read, 16'h0000);
    addr_read = 4'hC;
    #1 chk("reset const", data_read, 16'h0001);
    step();
    addr_read = 4'h4;
    #1 chk("pending write dropped", data_read, 16'h0000);
    addr_write = 4'h5; data_write = 16'h7777;
    rst = 0;
    step();
    write_enable = 0; pc_inc = 0;
    addr_read = 4'h5;
    #1 chk("post-reset write", data_read, 16'h7777);
    chk("post-reset inc", pc_out, 16'h0001);
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/core_registers.md
CORE_REGISTERS -- requirements
Module: core_registers

Interface
REQ-001 SHALL have clk, input, 1 bit: single core clock; all state updates occur on its rising edge.
REQ-002 SHALL have rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have addr_read, input, 4 bits: register index driving data_read.
REQ-004 SHALL have addr_write, input, 4 bits: register index written when write_enable=1.
REQ-005 SHALL have data_write, input, 16 bits: write data.
REQ-006 SHALL have write_enable, input, 1 bit: commit data_write to addr_write on the next rising clk.
REQ-007 SHALL have bus_datain, input, 16 bits: external bus value visible through the BUS register.
REQ-008 SHALL have bus_fromin, input, 1 bit: 1 = BUS register reads return bus_datain.
REQ-009 SHALL have pc_inc, input, 1 bit: increment PC by 1 on each rising clk while high.
REQ-010 SHALL have data_read, output, 16 bits: combinational contents of register addr_read.
REQ-011 SHALL have pc_out, output, 16 bits: current PC (register 0xF).
REQ-012 SHALL have reg_h_out, output, 16 bits: current H register (register 0x7).

Function
REQ-013 SHALL implement this register map:
- 0x0-0x7: A-H.
- 0x8: SCR1.
- 0x9: SCR2.
- 0xA: SP.
- 0xB: constant 0x0000.
- 0xC: constant 0x0001.
- 0xD: constant 0xFFFF.
- 0xE: BUS.
- 0xF: PC.
REQ-014 SHALL store 0x0-0xA, 0xE and 0xF as 16-bit writable registers.
REQ-015 SHALL ignore writes to 0xB-0xD; reads of these always return their constants.
REQ-016 SHALL drive data_read combinationally from addr_read and current state, with no clock latency.
REQ-017 On a write, the new value SHALL appear on data_read/pc_out/reg_h_out only after that rising edge; a same-cycle read returns the old value.
REQ-018 Reading 0xE SHALL return bus_datain when bus_fromin=1, else the stored BUS value.
REQ-019 Writes to 0xE SHALL update the stored BUS value regardless of bus_fromin.
REQ-020 pc_inc=1 SHALL give PC <= PC+1 at the edge, mod 2^16 (0xFFFF wraps to 0x0000).
REQ-021 pc_inc SHALL be level-sensitive: held for N cycles gives N increments.
REQ-022 write_enable=1 with addr_write=0xF and pc_inc=1 in the same cycle SHALL load data_write; the write wins and no increment occurs.
REQ-023 A write to any register other than PC SHALL proceed in parallel with a pc_inc increment in the same cycle.
REQ-024 write_enable=0 SHALL leave all state unchanged except the PC increment.
REQ-025 pc_out SHALL always equal the PC register, and reg_h_out the H register, independent of addr_read.
REQ-026 SHALL contain no other state, FSM or pipeline: one write port, one combinational read port, plus the two dedicated taps.

Reset
REQ-027 While rst=1, all writable registers, including BUS and PC, SHALL be 0x0000 asynchronously, without waiting for a clock edge.
REQ-028 While rst=1, pc_out=0x0000, reg_h_out=0x0000, and data_read follows addr_read (constants still readable).
REQ-029 rst=1 SHALL override write_enable and pc_inc.
REQ-030 Asserting rst mid-operation SHALL discard any pending write or increment.
REQ-031 After rst deasserts, the first rising clk SHALL process write_enable and pc_inc normally.

Verification
REQ-032 Write/read: write 0x1234 to 0x3, then addr_read=0x3 -> data_read=0x1234 after the edge; during the write cycle it shows 0x0000.
REQ-033 Constants: write 0xAAAA to 0xB, 0xC, 0xD -> reads stay 0x0000, 0x0001, 0xFFFF.
REQ-034 PC increment and wrap:
- pc_inc high 3 cycles from reset -> pc_out=0x0003.
- Write PC=0xFFFF, then pc_inc one cycle -> pc_out=0x0000.
REQ-035 PC conflict: write_enable=1, addr_write=0xF, data_write=0x0100, pc_inc=1 -> pc_out=0x0100 (not 0x0101).
REQ-036 H tap and BUS:
- Write 0xBEEF to 0x7 -> reg_h_out=0xBEEF.
- Write 0x5555 to 0xE; with bus_fromin=1 and bus_datain=0x9999, read 0xE -> 0x9999.
- Drop bus_fromin -> read 0xE returns 0x5555.
REQ-037 Async reset: load several registers, assert rst between clock edges -> all outputs 0x0000 immediately, before the next edge.
